// File: rtl/nv_ram_rws_fifo_rdctl.sv
// Valid/ready FIFO controller wrapped around an external two-port RAM with a
// registered read address; a 2-entry output buffer absorbs the read latency.
module nv_ram_rws_fifo_rdctl #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 768
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [AW+1:0] fifo_count
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          inflight;
    logic [1:0]    obuf_cnt;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;

    logic [AW:0]   slots_used;
    logic          pop;
    logic [2:0]    obuf_need;

    // A RAM slot stays occupied until its data has been captured from ram_dout,
    // so a write can never overwrite a slot whose read is still in flight.
    assign slots_used = ram_cnt + {{AW{1'b0}}, inflight};
    assign wr_prdy    = (slots_used < (AW+1)'(DEPTH));
    assign ram_we     = wr_pvld & wr_prdy;
    assign ram_wa     = wr_ptr;
    assign ram_di     = wr_pd;

    assign rd_pvld = (obuf_cnt != 2'd0);
    assign pop     = rd_pvld & rd_prdy;
    assign rd_pd   = head_q;

    // The pop credit is taken combinationally so a full-rate stream never bubbles.
    assign obuf_need = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign ram_re    = (ram_cnt != '0) && (obuf_need < 3'd2);
    assign ram_ra    = rd_ptr;

    assign fifo_count = {1'b0, ram_cnt}
                      + {{(AW+1){1'b0}}, inflight}
                      + {{AW{1'b0}}, obuf_cnt};

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({ram_we, ram_re})
                2'b10:   ram_cnt <= ram_cnt + (AW+1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (AW+1)'(1);
                default: ram_cnt <= ram_cnt;
            endcase
            inflight <= ram_re;
        end
    end

    // Head drives rd_pd; skid only fills when a capture lands while head is held.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            obuf_cnt <= 2'd0;
            head_q   <= '0;
            skid_q   <= '0;
        end else begin
            case (obuf_cnt)
                2'd0: begin
                    if (inflight) begin
                        head_q   <= ram_dout;
                        obuf_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && pop) begin
                        head_q <= ram_dout;
                    end else if (inflight) begin
                        skid_q   <= ram_dout;
                        obuf_cnt <= 2'd2;
                    end else if (pop) begin
                        obuf_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (inflight) begin
                            skid_q <= ram_dout;
                        end else begin
                            obuf_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nv_ram_rws_fifo_rdctl.sv
// Randomized and directed bench for nv_ram_rws_fifo_rdctl: a queue model of the
// FIFO contents plus a behavioural RAM, checked every cycle on the falling edge.
module tb_nv_ram_rws_fifo_rdctl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 768;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [AW+1:0] fifo_count;

    int n_vectors = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    nv_ram_rws_fifo_rdctl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .ram_we          (ram_we),
        .ram_wa          (ram_wa),
        .ram_di          (ram_di),
        .ram_re          (ram_re),
        .ram_ra          (ram_ra),
        .ram_dout        (ram_dout),
        .fifo_count      (fifo_count)
    );

    // Behavioural two-port RAM: registered read address, combinational dout.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int v);
        return {24{v}};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < 24; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    // Model: the FIFO is simply the ordered list of accepted beats not yet popped.
    logic [DW-1:0] exp_q [$];
    int            wr_total;
    int            issue_total;
    logic          held;
    logic [DW-1:0] held_pd;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wr_total    = 0;
            issue_total = 0;
            held        = 1'b0;
        end else begin
            check_output("fifo_count", DW'(fifo_count), DW'(exp_q.size()));
            check_output("ram_we", DW'(ram_we), DW'(wr_pvld & wr_prdy));
            if (ram_we) begin
                check_output("ram_wa", DW'(ram_wa), DW'(wr_total % DEPTH));
                check_output("ram_di", ram_di, wr_pd);
            end
            if (ram_re) check_output("ram_ra", DW'(ram_ra), DW'(issue_total % DEPTH));
            if (exp_q.size() < DEPTH) check_output("wr_prdy_free", DW'(wr_prdy), DW'(1));
            if (exp_q.size() == DEPTH + 2) check_output("wr_prdy_full", DW'(wr_prdy), DW'(0));
            if (exp_q.size() == 0) begin
                check_output("rd_pvld_empty", DW'(rd_pvld), DW'(0));
                check_output("ram_re_empty", DW'(ram_re), DW'(0));
            end
            if (held) begin
                check_output("rd_pvld_hold", DW'(rd_pvld), DW'(1));
                check_output("rd_pd_hold", rd_pd, held_pd);
            end
            if (rd_pvld && rd_prdy) begin
                if (exp_q.size() == 0) begin
                    check_output("rd_pvld_spurious", DW'(rd_pvld), DW'(0));
                end else begin
                    check_output("rd_pd_order", rd_pd, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            held    = rd_pvld & ~rd_prdy;
            held_pd = rd_pd;
            if (ram_we) begin
                exp_q.push_back(wr_pd);
                wr_total++;
            end
            if (ram_re) issue_total++;
        end
    end

    task automatic fill_to_full(input int base, output int accepted);
        accepted = 0;
        rd_prdy  = 1'b0;
        for (int c = 0; c < 41; c++) begin
            apply_stimulus();
            wr_pvld = 1'b1;
            wr_pd   = val(base + accepted);
            @(negedge clk);
            if (wr_prdy) accepted++;
        end
        apply_stimulus();
        wr_pvld = 1'b0;
    endtask

    logic [DW-1:0] a5_pat;
    logic [DW-1:0] new_pat;
    int acc, k, old_idx, new_idx, sent, got, bubbles, wa_wraps, ra_wraps, pops;
    bit started, taken;

    initial begin
        wr_pvld = 1'b0;
        wr_pd   = '0;
        rd_prdy = 1'b0;
        a5_pat  = {96{8'hA5}};
        new_pat = {96{8'h3C}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_wr_prdy", DW'(wr_prdy), DW'(1));
        check_output("rst_rd_pvld", DW'(rd_pvld), DW'(0));
        check_output("rst_ram_re", DW'(ram_re), DW'(0));
        check_output("rst_ram_we", DW'(ram_we), DW'(0));
        check_output("rst_rd_pd", rd_pd, '0);
        check_output("rst_fifo_count", DW'(fifo_count), DW'(0));
        apply_stimulus();
        rst_n = 1'b1;

        // Single beat latency
        apply_stimulus();
        wr_pvld = 1'b1;
        wr_pd   = a5_pat;
        rd_prdy = 1'b1;
        @(negedge clk);
        check_output("beat_c0_we", DW'(ram_we), DW'(1));
        apply_stimulus();
        wr_pvld = 1'b0;
        @(negedge clk);
        check_output("beat_c1_re", DW'(ram_re), DW'(1));
        check_output("beat_c1_ra", DW'(ram_ra), DW'(0));
        apply_stimulus();
        @(negedge clk);
        check_output("beat_c2_pvld", DW'(rd_pvld), DW'(0));
        apply_stimulus();
        @(negedge clk);
        check_output("beat_c3_pvld", DW'(rd_pvld), DW'(1));
        check_output("beat_c3_pd", rd_pd, a5_pat);
        apply_stimulus();
        @(negedge clk);
        check_output("beat_c4_count", DW'(fifo_count), DW'(0));

        // Fill to capacity, then drain
        fill_to_full(0, acc);
        @(negedge clk);
        check_output("fill_accepted", DW'(acc), DW'(34));
        check_output("fill_wr_prdy", DW'(wr_prdy), DW'(0));
        check_output("fill_count", DW'(fifo_count), DW'(34));
        apply_stimulus();
        rd_prdy = 1'b1;
        k = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 0 || c == 1) check_output("drain_wr_prdy_low", DW'(wr_prdy), DW'(0));
            if (c == 2) check_output("drain_wr_prdy_rise", DW'(wr_prdy), DW'(1));
            if (rd_pvld && rd_prdy) begin
                check_output("drain_value", rd_pd, val(k));
                k++;
            end
            apply_stimulus();
        end
        check_output("drain_total", DW'(k), DW'(34));

        // Same-slot hazard: free exactly one slot of a full RAM and rewrite it
        fill_to_full(1000, acc);
        rd_prdy = 1'b1;
        @(negedge clk);
        apply_stimulus();
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        wr_pd   = new_pat;
        taken   = 1'b0;
        for (int c = 0; c < 10 && !taken; c++) begin
            @(negedge clk);
            if (wr_prdy) taken = 1'b1;
            apply_stimulus();
        end
        wr_pvld = 1'b0;
        check_output("hazard_write_taken", DW'(taken), DW'(1));
        rd_prdy = 1'b1;
        k = 1;
        old_idx = -1;
        new_idx = -1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (rd_pvld && rd_prdy) begin
                if (rd_pd == val(1002)) old_idx = k;
                if (rd_pd == new_pat) new_idx = k;
                k++;
            end
            apply_stimulus();
        end
        check_output("hazard_old_idx", DW'(old_idx), DW'(2));
        check_output("hazard_new_idx", DW'(new_idx), DW'(34));

        // Wrap: 100 beats at full rate from reset
        rst_n = 1'b0;
        apply_stimulus();
        rst_n = 1'b1;
        rd_prdy = 1'b1;
        sent = 0; got = 0; bubbles = 0; wa_wraps = 0; ra_wraps = 0; started = 1'b0;
        for (int c = 0; c < 110; c++) begin
            wr_pvld = (sent < 100);
            wr_pd   = val(5000 + sent);
            @(negedge clk);
            if (ram_we) begin
                if (ram_wa == AW'(DEPTH - 1)) wa_wraps++;
                sent++;
            end
            if (ram_re && ram_ra == AW'(DEPTH - 1)) ra_wraps++;
            if (rd_pvld) begin
                started = 1'b1;
                got++;
            end else if (started && got < 100) begin
                bubbles++;
            end
            apply_stimulus();
        end
        wr_pvld = 1'b0;
        check_output("wrap_received", DW'(got), DW'(100));
        check_output("wrap_bubbles", DW'(bubbles), DW'(0));
        check_output("wrap_wa_wraps", DW'(wa_wraps), DW'(3));
        check_output("wrap_ra_wraps", DW'(ra_wraps), DW'(3));

        // Random backpressure with continuous writes
        pops = 0;
        for (int c = 0; c < 4000 && pops < 1000; c++) begin
            wr_pvld = 1'b1;
            wr_pd   = rand_word();
            rd_prdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rd_pvld && rd_prdy) pops++;
            apply_stimulus();
        end
        check_output("random_pops", DW'(pops >= 1000), DW'(1));
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        repeat (60) apply_stimulus();
        @(negedge clk);
        check_output("random_drained", DW'(fifo_count), DW'(0));

        // Asynchronous reset mid-stream
        apply_stimulus();
        rd_prdy = 1'b0;
        for (int c = 0; c < 17; c++) begin
            wr_pvld = 1'b1;
            wr_pd   = val(7000 + c);
            apply_stimulus();
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        check_output("areset_pre_count", DW'(fifo_count), DW'(17));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("areset_rd_pvld", DW'(rd_pvld), DW'(0));
        check_output("areset_wr_prdy", DW'(wr_prdy), DW'(1));
        check_output("areset_count", DW'(fifo_count), DW'(0));
        apply_stimulus();
        apply_stimulus();
        rst_n = 1'b1;
        apply_stimulus();
        wr_pvld = 1'b1;
        wr_pd   = val(9999);
        rd_prdy = 1'b1;
        @(negedge clk);
        apply_stimulus();
        wr_pvld = 1'b0;
        @(negedge clk);
        check_output("areset_ram_re", DW'(ram_re), DW'(1));
        check_output("areset_ram_ra", DW'(ram_ra), DW'(0));
        apply_stimulus();
        apply_stimulus();
        @(negedge clk);
        check_output("areset_readback", rd_pd, val(9999));
        repeat (3) apply_stimulus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
